gshare_btb_predictor: RTL



---
 rtl/gshare_btb_predictor_if.sv | 39 +++
 rtl/gshare_btb_predictor.sv | 107 ++++++++++
 2 files changed

// File: rtl/gshare_btb_predictor_if.sv
// gshare_btb_predictor_if
//   Groups the fetch-side prediction bus, the execute-side training bus
//   and the performance counters of the gshare/BTB branch predictor.
//   master : pipeline side (drives fetch_* and upd_*, observes predictions)
//   slave  : predictor side (drives pred_* and the counters)
interface gshare_btb_predictor_if #(
    parameter int HIST_BITS = 8
);
    // fetch / predict
    logic                 fetch_valid;
    logic [31:0]          fetch_pc;
    logic                 pred_taken;
    logic [31:0]          pred_target;
    logic [HIST_BITS-1:0] pred_hist;
    // execute-stage training
    logic                 upd_valid;
    logic [31:0]          upd_pc;
    logic [HIST_BITS-1:0] upd_hist;
    logic                 upd_taken;
    logic [31:0]          upd_target;
    logic                 upd_mispredict;
    // performance counters
    logic [31:0]          branch_count;
    logic [31:0]          mispredict_count;

    modport master (
        output fetch_valid, fetch_pc,
        output upd_valid, upd_pc, upd_hist, upd_taken, upd_target, upd_mispredict,
        input  pred_taken, pred_target, pred_hist,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        input  upd_valid, upd_pc, upd_hist, upd_taken, upd_target, upd_mispredict,
        output pred_taken, pred_target, pred_hist,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor
//   gshare PHT (PC xor speculative global history) plus a direct-mapped BTB.
//   Predictions are combinational from fetch_pc and current state; training,
//   history repair and counters update on the rising clock edge.
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bp       : predictor bus (slave modport), see gshare_btb_predictor_if
module gshare_btb_predictor #(
    parameter int HIST_BITS    = 8,
    parameter int IDX_BITS     = 10,
    parameter int CTR_BITS     = 2,
    parameter int BTB_IDX_BITS = 6,
    parameter int TAG_BITS     = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    gshare_btb_predictor_if.slave  bp
);
    localparam int PHT_N = 1 << IDX_BITS;
    localparam int BTB_N = 1 << BTB_IDX_BITS;
    localparam int TAG_LO = BTB_IDX_BITS + 2;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic [CTR_BITS-1:0]  pht_q     [PHT_N];
    logic [BTB_N-1:0]     btb_vld_q;
    logic [TAG_BITS-1:0]  btb_tag_q [BTB_N];
    logic [31:0]          btb_tgt_q [BTB_N];
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]          br_cnt_q, mp_cnt_q;

    logic [IDX_BITS-1:0]     f_idx, u_idx;
    logic [BTB_IDX_BITS-1:0] f_bidx, u_bidx;
    logic [TAG_BITS-1:0]     f_tag, u_tag;
    logic                    f_hit, f_taken;
    logic [CTR_BITS-1:0]     u_ctr_d;
    logic                    unused_upd_pc;

    // ---------------- lookup ----------------
    assign f_idx  = bp.fetch_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign u_idx  = bp.upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(bp.upd_hist);
    assign f_bidx = bp.fetch_pc[BTB_IDX_BITS+1:2];
    assign u_bidx = bp.upd_pc[BTB_IDX_BITS+1:2];
    assign f_tag  = bp.fetch_pc[TAG_LO+TAG_BITS-1:TAG_LO];
    assign u_tag  = bp.upd_pc[TAG_LO+TAG_BITS-1:TAG_LO];

    // only index/tag bits of upd_pc matter; fold the rest away
    assign unused_upd_pc = ^bp.upd_pc;

    // Registered arrays mean a same-cycle write is not seen until next cycle.
    assign f_hit   = btb_vld_q[f_bidx] && (btb_tag_q[f_bidx] == f_tag);
    assign f_taken = f_hit && pht_q[f_idx][CTR_BITS-1];

    assign bp.pred_taken       = f_taken;
    assign bp.pred_target      = f_taken ? btb_tgt_q[f_bidx] : bp.fetch_pc + 32'd4;
    assign bp.pred_hist        = ghr_q;
    assign bp.branch_count     = br_cnt_q;
    assign bp.mispredict_count = mp_cnt_q;

    // ---------------- next state ----------------
    always_comb begin
        u_ctr_d = pht_q[u_idx];
        if (bp.upd_taken) begin
            if (u_ctr_d != CTR_MAX) u_ctr_d = u_ctr_d + CTR_BITS'(1);
        end else begin
            if (u_ctr_d != '0) u_ctr_d = u_ctr_d - CTR_BITS'(1);
        end
    end

    // Repair from the resolved branch wins over the speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (bp.upd_valid && bp.upd_mispredict)
            ghr_d = {bp.upd_hist[HIST_BITS-2:0], bp.upd_taken};
        else if (bp.fetch_valid && f_hit)
            ghr_d = {ghr_q[HIST_BITS-2:0], f_taken};
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_WNT;
            btb_vld_q <= '0;
            ghr_q     <= '0;
            br_cnt_q  <= '0;
            mp_cnt_q  <= '0;
        end else begin
            ghr_q <= ghr_d;
            if (bp.upd_valid) begin
                pht_q[u_idx] <= u_ctr_d;
                br_cnt_q     <= br_cnt_q + 32'd1;
                if (bp.upd_mispredict) mp_cnt_q <= mp_cnt_q + 32'd1;
                // taken outcomes allocate; not-taken never touches the BTB
                if (bp.upd_taken) btb_vld_q[u_bidx] <= 1'b1;
            end
        end
    end

    // Tag/target payload is only meaningful behind a valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (reset_n && bp.upd_valid && bp.upd_taken) begin
            btb_tag_q[u_bidx] <= u_tag;
            btb_tgt_q[u_bidx] <= bp.upd_target;
        end
    end
endmodule
